// File: rtl/riscv_pkg.sv
// riscv_pkg
// Types and constants shared by the pipeline core and the unified-memory
// arbiter. The arbiter uses the requester owner tag, its two-state FSM
// encoding and the counter widths. The opcode constants belong to the core's
// decoder.
// No ports (package).
package riscv_pkg;

  // Which requester owns the in-flight memory access
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Arbiter sequencing states
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  // lat_cnt holds MEM_LAT-1 (MEM_LAT is 1..4).
  // starve_cnt counts up to STARVE_MAX (1..15).
  localparam int LAT_W    = 2;
  localparam int STARVE_W = 4;

  // Bit positions inside the one-hot grant vector from arb_pick
  localparam int GNT_IF = 0;
  localparam int GNT_LS = 1;

  // RV32I major opcodes used by the core decoder
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the signals between the core's two requesters (fetch and load/store),
// the arbiter, and the single-port memory.
//   if_*  : fetch request/grant/response
//   ls_*  : load/store request/grant/response
//   mem_* : memory strobe, address, write data and read data
// Modports:
//   slave  - the arbiter's view. It receives requests and mem_rdata and drives
//            grants, responses and the memory strobe.
//   master - the environment's view (core requesters plus memory model).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [3:0]        ls_wstrb;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata
  );

endinterface

// File: rtl/arb_pick.sv
// arb_pick
// Combinational winner select for mem_arbiter. This block holds only the
// policy. Sequencing and availability live in the top.
// Configuration macro: MEM_ARB_RR_EN
//   defined   - round robin. On a collision the requester that did not win
//               last time gets the grant.
//   undefined - load/store has priority. Fetch wins a collision once
//               starve_cnt reaches STARVE_MAX.
// Ports:
//   if_req, ls_req - raw request lines
//   rr_last        - last winner (round-robin build only)
//   starve_cnt     - LS grants given while fetch waited (fixed-priority build only)
//   gnt            - one-hot grant, bit GNT_IF / GNT_LS, all-zero when no request
module arb_pick
  import riscv_pkg::*;
`ifndef MEM_ARB_RR_EN
#(
  parameter int STARVE_MAX = 4
)
`endif
(
  input  logic                if_req,
  input  logic                ls_req,
`ifdef MEM_ARB_RR_EN
  input  owner_t              rr_last,
`else
  input  logic [STARVE_W-1:0] starve_cnt,
`endif
  output logic [1:0]          gnt
);

  // Decide whether fetch takes a collision; every other case is unambiguous
  logic if_first;

`ifdef MEM_ARB_RR_EN
  assign if_first = (rr_last == OWN_LS);
`else
  assign if_first = (starve_cnt == STARVE_W'(STARVE_MAX));
`endif

  // Fetch wins when it is alone or when the policy favours it on a collision
  always_comb begin
    gnt = '0;
    if (if_req && (!ls_req || if_first)) begin
      gnt[GNT_IF] = 1'b1;
    end else if (ls_req) begin
      gnt[GNT_LS] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port, fixed-latency memory between instruction fetch and
// load/store. Only one access is outstanding at a time. Each response goes
// back to the requester that owns the access. Grants are combinational in the
// request cycle. The response comes MEM_LAT edges later, and a new grant may
// be issued in that response cycle.
// Configuration macro: MEM_ARB_RR_EN (round robin instead of LS priority with
// a fetch starvation guard; see arb_pick).
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous reset, active low
//   bus - mem_arbiter_if.slave (requester handshakes and memory port)
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
)(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [DATA_W-1:0] ZERO_DATA = '0;
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(MEM_LAT - 1);

  arb_state_t          state, state_next;
  owner_t              owner, owner_next;
  logic [LAT_W-1:0]    lat_cnt, lat_next;
  logic                store_q, store_next;
`ifdef MEM_ARB_RR_EN
  localparam int unused_starve_max = STARVE_MAX;
  owner_t              rr_last, rr_next;
`else
  logic [STARVE_W-1:0] starve_cnt, starve_next;
`endif

  logic [1:0] pick;
  logic       available, respond, grant_if, grant_ls, resp_if, resp_ls;
  logic       unused_addr_bits;

  // Byte-offset bits are not used. Sub-word selection is done in the LSU.
  assign unused_addr_bits = ^{bus.if_addr[1:0], bus.ls_addr[1:0]};

  arb_pick
`ifndef MEM_ARB_RR_EN
    #(.STARVE_MAX(STARVE_MAX))
`endif
  u_pick (
    .if_req     (bus.if_req),
    .ls_req     (bus.ls_req),
`ifdef MEM_ARB_RR_EN
    .rr_last    (rr_last),
`else
    .starve_cnt (starve_cnt),
`endif
    .gnt        (pick)
  );

  // The arbiter can take a new request when idle, or in the response cycle
  // of the access in flight. Holding rst low forces every output to zero at
  // once, even though the grant path is combinational.
  always_comb begin
    available = rst && ((state == ARB_IDLE) || (lat_cnt == '0));
    respond   = rst && (state == ARB_WAIT) && (lat_cnt == '0);
    grant_if  = available && pick[GNT_IF];
    grant_ls  = available && pick[GNT_LS];
    resp_if   = respond && (owner == OWN_IF);
    resp_ls   = respond && (owner == OWN_LS);
  end

  // Route the winner onto the memory port and the memory data back to the
  // owner. A store completion returns zero data.
  always_comb begin
    bus.if_gnt    = grant_if;
    bus.ls_gnt    = grant_ls;
    bus.mem_en    = grant_if || grant_ls;
    bus.mem_we    = grant_ls && bus.ls_we;
    bus.mem_addr  = '0;
    bus.mem_wdata = ZERO_DATA;
    bus.mem_wstrb = '0;
    if (grant_ls) begin
      bus.mem_addr  = bus.ls_addr[ADDR_W-1:2];
      bus.mem_wdata = bus.ls_wdata;
      bus.mem_wstrb = bus.ls_wstrb;
    end else if (grant_if) begin
      bus.mem_addr  = bus.if_addr[ADDR_W-1:2];
    end
    bus.if_rvalid = resp_if;
    bus.ls_rvalid = resp_ls;
    bus.if_rdata  = resp_if ? bus.mem_rdata : ZERO_DATA;
    bus.ls_rdata  = (resp_ls && !store_q) ? bus.mem_rdata : ZERO_DATA;
  end

  // Next-state logic. A grant starts a new access and reloads the latency
  // counter. While waiting, the counter runs down to the response cycle.
  // The policy state (starve count or last winner) follows every grant.
  always_comb begin
    state_next  = state;
    owner_next  = owner;
    lat_next    = lat_cnt;
    store_next  = store_q;
`ifdef MEM_ARB_RR_EN
    rr_next     = rr_last;
`else
    starve_next = starve_cnt;
`endif
    if (available) begin
      if (grant_if || grant_ls) begin
        state_next = ARB_WAIT;
        owner_next = grant_ls ? OWN_LS : OWN_IF;
        lat_next   = LAT_LOAD;
        store_next = grant_ls && bus.ls_we;
      end else begin
        state_next = ARB_IDLE;
        store_next = 1'b0;
      end
    end else begin
      lat_next = lat_cnt - 1'b1;
    end
`ifdef MEM_ARB_RR_EN
    if (grant_if) begin
      rr_next = OWN_IF;
    end else if (grant_ls) begin
      rr_next = OWN_LS;
    end
`else
    // Count only the LS grants that made fetch wait
    if (grant_if) begin
      starve_next = '0;
    end else if (grant_ls && bus.if_req) begin
      starve_next = starve_cnt + 1'b1;
    end
`endif
  end

  // State registers. Reset aborts any access in flight, so no response follows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      owner      <= OWN_IF;
      lat_cnt    <= '0;
      store_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_last    <= OWN_LS;
`else
      starve_cnt <= '0;
`endif
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      lat_cnt    <= lat_next;
      store_q    <= store_next;
`ifdef MEM_ARB_RR_EN
      rr_last    <= rr_next;
`else
      starve_cnt <= starve_next;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Drives two arbiters side by side, one with MEM_LAT=1/STARVE_MAX=4 and one
// with MEM_LAT=3/STARVE_MAX=2. Inputs are applied on the falling edge, and
// outputs are compared 1 time unit later against a transaction-level model.
// The model tracks the cycle in which the in-flight access answers, the
// owner of that access, and the policy history.
// Honours MEM_ARB_RR_EN in the same way as the design.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) d0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
  );
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(2)) d1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic rst_drv;

  // Stimulus per DUT
  logic        s_if_req [2];
  logic [31:0] s_if_addr [2];
  logic        s_ls_req [2];
  logic        s_ls_we [2];
  logic [31:0] s_ls_addr [2];
  logic [31:0] s_ls_wdata [2];
  logic [3:0]  s_ls_wstrb [2];
  logic [31:0] s_mem_rdata [2];

  // Observed outputs per DUT
  logic [1:0]  o_gnt [2];
  logic [1:0]  o_mem [2];
  logic [29:0] o_maddr [2];
  logic [31:0] o_wdata [2];
  logic [3:0]  o_wstrb [2];
  logic [1:0]  o_rv [2];
  logic [31:0] o_ifrd [2];
  logic [31:0] o_lsrd [2];

  // Reference model state per DUT
  int    m_resp_cyc [2];
  bit    m_owner_ls [2];
  bit    m_store [2];
  int    m_starve [2];
  bit    m_last_ls [2];
  logic [1:0] m_win [2];
  string glog [2];

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic int starve_of(input int u);
    return (u == 0) ? 4 : 2;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag, input string obs, input string exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%s expected=%s", tag, obs, exp);
    end
  endtask

  task automatic drive_pins();
    rst          = rst_drv;
    b0.if_req    = s_if_req[0];   b1.if_req    = s_if_req[1];
    b0.if_addr   = s_if_addr[0];  b1.if_addr   = s_if_addr[1];
    b0.ls_req    = s_ls_req[0];   b1.ls_req    = s_ls_req[1];
    b0.ls_we     = s_ls_we[0];    b1.ls_we     = s_ls_we[1];
    b0.ls_addr   = s_ls_addr[0];  b1.ls_addr   = s_ls_addr[1];
    b0.ls_wdata  = s_ls_wdata[0]; b1.ls_wdata  = s_ls_wdata[1];
    b0.ls_wstrb  = s_ls_wstrb[0]; b1.ls_wstrb  = s_ls_wstrb[1];
    b0.mem_rdata = s_mem_rdata[0]; b1.mem_rdata = s_mem_rdata[1];
  endtask

  task automatic sample_pins();
    o_gnt[0]   = {b0.if_gnt, b0.ls_gnt};       o_gnt[1]   = {b1.if_gnt, b1.ls_gnt};
    o_mem[0]   = {b0.mem_en, b0.mem_we};       o_mem[1]   = {b1.mem_en, b1.mem_we};
    o_maddr[0] = b0.mem_addr;                  o_maddr[1] = b1.mem_addr;
    o_wdata[0] = b0.mem_wdata;                 o_wdata[1] = b1.mem_wdata;
    o_wstrb[0] = b0.mem_wstrb;                 o_wstrb[1] = b1.mem_wstrb;
    o_rv[0]    = {b0.if_rvalid, b0.ls_rvalid}; o_rv[1]    = {b1.if_rvalid, b1.ls_rvalid};
    o_ifrd[0]  = b0.if_rdata;                  o_ifrd[1]  = b1.if_rdata;
    o_lsrd[0]  = b0.ls_rdata;                  o_lsrd[1]  = b1.ls_rdata;
  endtask

  // One cycle of the reference model: expected outputs, compare, then advance
  task automatic model_cycle(input int u);
    logic avail, resp, win_if, win_ls;
    logic [1:0]  e_gnt, e_mem, e_rv;
    logic [63:0] e_maddr, e_wdata, e_wstrb, e_ifrd, e_lsrd;
    win_if = 1'b0;
    win_ls = 1'b0;
    resp   = 1'b0;
    avail  = 1'b0;
    if (rst_drv) begin
      resp  = (m_resp_cyc[u] == cyc);
      avail = (cyc >= m_resp_cyc[u]);
      if (avail && s_if_req[u] && s_ls_req[u]) begin
`ifdef MEM_ARB_RR_EN
        win_if = m_last_ls[u];
`else
        win_if = (m_starve[u] == starve_of(u));
`endif
        win_ls = !win_if;
      end else if (avail) begin
        win_if = s_if_req[u];
        win_ls = s_ls_req[u];
      end
    end
    e_gnt   = {win_if, win_ls};
    e_mem   = {win_if | win_ls, win_ls & s_ls_we[u]};
    e_maddr = win_ls ? 64'(s_ls_addr[u] >> 2) : (win_if ? 64'(s_if_addr[u] >> 2) : 64'd0);
    e_wdata = win_ls ? 64'(s_ls_wdata[u]) : 64'd0;
    e_wstrb = win_ls ? 64'(s_ls_wstrb[u]) : 64'd0;
    e_rv    = {resp & ~m_owner_ls[u], resp & m_owner_ls[u]};
    e_ifrd  = e_rv[1] ? 64'(s_mem_rdata[u]) : 64'd0;
    e_lsrd  = (e_rv[0] && !m_store[u]) ? 64'(s_mem_rdata[u]) : 64'd0;

    check_output($sformatf("u%0d.gnt c%0d", u, cyc),       64'(o_gnt[u]),   64'(e_gnt));
    check_output($sformatf("u%0d.en_we c%0d", u, cyc),     64'(o_mem[u]),   64'(e_mem));
    check_output($sformatf("u%0d.mem_addr c%0d", u, cyc),  64'(o_maddr[u]), e_maddr);
    check_output($sformatf("u%0d.mem_wdata c%0d", u, cyc), 64'(o_wdata[u]), e_wdata);
    check_output($sformatf("u%0d.mem_wstrb c%0d", u, cyc), 64'(o_wstrb[u]), e_wstrb);
    check_output($sformatf("u%0d.rvalid c%0d", u, cyc),    64'(o_rv[u]),    64'(e_rv));
    check_output($sformatf("u%0d.if_rdata c%0d", u, cyc),  64'(o_ifrd[u]),  e_ifrd);
    check_output($sformatf("u%0d.ls_rdata c%0d", u, cyc),  64'(o_lsrd[u]),  e_lsrd);

    if (!rst_drv) begin
      m_resp_cyc[u] = -1;
      m_owner_ls[u] = 1'b0;
      m_store[u]    = 1'b0;
      m_starve[u]   = 0;
      m_last_ls[u]  = 1'b1;
    end else begin
      if (win_if || win_ls) begin
        m_resp_cyc[u] = cyc + lat_of(u);
        m_owner_ls[u] = win_ls;
        m_store[u]    = win_ls & s_ls_we[u];
        glog[u]       = {glog[u], win_ls ? "L" : "I"};
      end
      if (win_if) begin
        m_starve[u]  = 0;
        m_last_ls[u] = 1'b0;
      end else if (win_ls) begin
        if (s_if_req[u]) m_starve[u]++;
        m_last_ls[u] = 1'b1;
      end
    end
    m_win[u] = e_gnt;
  endtask

  task automatic step();
    @(negedge clk);
    drive_pins();
    #1;
    sample_pins();
    for (int u = 0; u < 2; u++) model_cycle(u);
    cyc++;
  endtask

  // A granted request is consumed; the requester goes quiet until refilled
  task automatic retire_granted();
    for (int u = 0; u < 2; u++) begin
      if (m_win[u][1]) s_if_req[u] = 1'b0;
      if (m_win[u][0]) s_ls_req[u] = 1'b0;
    end
  endtask

  task automatic advance();
    step();
    retire_granted();
  endtask

  task automatic set_if(input logic req, input logic [31:0] addr);
    for (int u = 0; u < 2; u++) begin
      s_if_req[u]  = req;
      s_if_addr[u] = addr;
    end
  endtask

  task automatic set_ls(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
    for (int u = 0; u < 2; u++) begin
      s_ls_req[u]   = req;
      s_ls_we[u]    = we;
      s_ls_addr[u]  = addr;
      s_ls_wdata[u] = wdata;
      s_ls_wstrb[u] = wstrb;
    end
  endtask

  task automatic set_rdata(input logic [31:0] d);
    for (int u = 0; u < 2; u++) s_mem_rdata[u] = d;
  endtask

  task automatic drain(input int n);
    set_if(1'b0, 32'h0);
    s_ls_req[0] = 1'b0;
    s_ls_req[1] = 1'b0;
    repeat (n) advance();
  endtask

  // Random requesters: operands stay put while a request is pending; an
  // occasional pending request is withdrawn before its grant.
  task automatic apply_stimulus(input int u);
    if (m_win[u][1] || !s_if_req[u]) begin
      s_if_req[u]  = ($urandom_range(0, 3) != 0);
      s_if_addr[u] = $urandom();
    end else if ($urandom_range(0, 15) == 0) begin
      s_if_req[u] = 1'b0;
    end
    if (m_win[u][0] || !s_ls_req[u]) begin
      s_ls_req[u]   = ($urandom_range(0, 2) != 0);
      s_ls_we[u]    = $urandom_range(0, 1) == 1;
      s_ls_addr[u]  = $urandom();
      s_ls_wdata[u] = $urandom();
      s_ls_wstrb[u] = 4'($urandom_range(0, 15));
    end else if ($urandom_range(0, 15) == 0) begin
      s_ls_req[u] = 1'b0;
    end
    s_mem_rdata[u] = $urandom();
  endtask

  initial begin
    rst_drv = 1'b0;
    rst     = 1'b0;
    for (int u = 0; u < 2; u++) begin
      m_resp_cyc[u] = -1;
      m_owner_ls[u] = 1'b0;
      m_store[u]    = 1'b0;
      m_starve[u]   = 0;
      m_last_ls[u]  = 1'b1;
      m_win[u]      = 2'b00;
      glog[u]       = "";
    end
    set_if(1'b0, 32'h0);
    set_ls(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_rdata(32'h0);

    $display("[TB] reset with a fetch already requested");
    set_if(1'b1, 32'h8);
    advance();
    advance();
    rst_drv = 1'b1;
    advance();
    check_output("plan.fetch_gnt", 64'(o_gnt[0]), 64'h2);
    check_output("plan.fetch_addr", 64'(o_maddr[0]), 64'h2);
    set_rdata(32'h1234_5678);
    advance();
    check_output("plan.fetch_rvalid", 64'(o_rv[0]), 64'h2);
    check_output("plan.fetch_rdata", 64'(o_ifrd[0]), 64'h1234_5678);
    drain(4);

    $display("[TB] word store");
    set_ls(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    advance();
    check_output("plan.store_en_we", 64'(o_mem[0]), 64'h3);
    check_output("plan.store_addr", 64'(o_maddr[0]), 64'h4);
    set_rdata(32'hCAFE_F00D);
    advance();
    check_output("plan.store_rvalid", 64'(o_rv[0]), 64'h1);
    check_output("plan.store_rdata", 64'(o_lsrd[0]), 64'h0);
    drain(4);

    $display("[TB] both requesters held continuously");
    set_if(1'b1, 32'h80);
    advance();
    drain(3);
    glog[0] = "";
    glog[1] = "";
    for (int k = 0; k < 12; k++) begin
      for (int u = 0; u < 2; u++) begin
        if (!s_if_req[u]) begin
          s_if_req[u]  = 1'b1;
          s_if_addr[u] = 32'h100 + 32'(k * 4);
        end
        if (!s_ls_req[u]) begin
          s_ls_req[u]   = 1'b1;
          s_ls_we[u]    = k[0];
          s_ls_addr[u]  = 32'h200 + 32'(k * 4);
          s_ls_wdata[u] = $urandom();
          s_ls_wstrb[u] = 4'hF;
        end
        s_mem_rdata[u] = $urandom();
      end
      advance();
    end
`ifdef MEM_ARB_RR_EN
    check_log("pattern.lat1", glog[0], "LILILILILILI");
    check_log("pattern.lat3", glog[1], "LILI");
`else
    check_log("pattern.lat1", glog[0], "LLLLILLLLILL");
    check_log("pattern.lat3", glog[1], "LLIL");
`endif
    drain(4);

    $display("[TB] fetch withdrawn while load/store keeps the memory busy");
    set_if(1'b1, 32'h84);
    advance();
    drain(3);
    glog[0] = "";
    glog[1] = "";
    for (int k = 0; k < 10; k++) begin
      for (int u = 0; u < 2; u++) begin
        if (k >= 2 && k < 5) begin
          s_if_req[u] = 1'b0;
        end else if (!s_if_req[u]) begin
          s_if_req[u]  = 1'b1;
          s_if_addr[u] = 32'h300 + 32'(k * 4);
        end
        if (!s_ls_req[u]) begin
          s_ls_req[u]   = 1'b1;
          s_ls_we[u]    = 1'b0;
          s_ls_addr[u]  = 32'h400 + 32'(k * 4);
          s_ls_wdata[u] = 32'h0;
          s_ls_wstrb[u] = 4'h0;
        end
        s_mem_rdata[u] = $urandom();
      end
      advance();
    end
`ifndef MEM_ARB_RR_EN
    check_log("drop.lat1", glog[0], "LLLLLLLILL");
`endif
    drain(4);

    $display("[TB] reset one cycle after a load grant");
    set_ls(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    advance();
    rst_drv = 1'b0;
    set_rdata(32'hFFFF_FFFF);
    set_if(1'b1, 32'h44);
    advance();
    check_output("rst.lat3_rvalid", 64'(o_rv[1]), 64'h0);
    advance();
    rst_drv = 1'b1;
    advance();
    check_output("rst.next_gnt", 64'(o_gnt[0]), 64'h2);
    drain(4);
    check_output("rst.lat3_no_ls_rvalid", 64'(o_rv[1]), 64'h0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 700; n++) begin
      for (int u = 0; u < 2; u++) apply_stimulus(u);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-port, fixed-latency memory between the processor's instruction-fetch stage and its load/store stage. It sits between the pipeline core and a unified program/data memory, so the core does not need separate `program_mem`/`data_mem` arrays. It sequences one outstanding transaction at a time and routes responses back to the owning requester. It also bounds fetch starvation under heavy load/store traffic.

## Interface
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, data width (must be 32)
- `MEM_LAT`, 1, memory read latency in cycles, range 1..4
- `STARVE_MAX`, 4, consecutive LSU grants allowed while fetch waits, range 1..15
---
- `clk`  input  1  clock, rising edge
- `rst`  input  1  reset; asynchronous, active-low (asserted at 0)
- `if_req`  input  1  fetch request, held until `if_gnt`
- `if_addr`  input  ADDR_W  fetch byte address
- `if_gnt`  output  1  fetch accepted this cycle
- `if_rvalid`  output  1  fetch data valid
- `if_rdata`  output  DATA_W  fetched instruction
- `ls_req`  input  1  load/store request, held until `ls_gnt`
- `ls_we`  input  1  1 = store
- `ls_addr`  input  ADDR_W  load/store byte address
- `ls_wdata`  input  DATA_W  store data
- `ls_wstrb`  input  4  byte enables (SB/SH/SW)
- `ls_gnt`  output  1  load/store accepted this cycle
- `ls_rvalid`  output  1  load data valid / store complete
- `ls_rdata`  output  DATA_W  load data (0 on store completion)
- `mem_en`  output  1  memory access strobe
- `mem_we`  output  1  memory write
- `mem_addr`  output  ADDR_W-2  word address (`addr >> 2`)
- `mem_wdata`  output  DATA_W  write data
- `mem_wstrb`  output  4  write byte enables
- `mem_rdata`  input  DATA_W  read data, valid MEM_LAT cycles after `mem_en`

## Operation
- State machine with two states: IDLE and WAIT. It holds registers `owner` (IF/LS), `lat_cnt`, `starve_cnt` and `rr_last`.
- The arbiter is *available* in IDLE, and in WAIT when `lat_cnt == 0` (the response cycle).
- When available and at least one request is present, the arbiter picks a winner combinationally:
  - it drives the winner's `*_gnt`;
  - it drives `mem_en=1` and muxes that requester's `addr`/`we`/`wdata`/`wstrb` onto the `mem_*` outputs;
  - at the clock edge it latches `owner`, sets `lat_cnt = MEM_LAT-1` and goes to WAIT.
- When available with no request: `mem_en=0` and the next state is IDLE.
- Default policy is fixed priority, LSU over fetch:
  - `starve_cnt` increments on every LS grant made while `if_req` is high;
  - `starve_cnt` clears on every IF grant;
  - when `starve_cnt == STARVE_MAX` and both requesters are present, fetch wins.
- WAIT with `lat_cnt > 0`: `lat_cnt` decrements, no grants, `mem_en=0`.
- WAIT with `lat_cnt == 0`: the owner's `*_rvalid=1` and `*_rdata = mem_rdata` (`ls_rdata = 0` if the access was a store). A new grant may be issued in the same cycle.
- The non-owner's `rvalid` is always 0. Each `rdata` reads 0 whenever its `rvalid` is 0.
- `mem_addr` drops bits [1:0]. Misaligned addresses are not checked; sub-word extraction is the LSU's job.

## Timing
- Reset (`rst=0`, asynchronous): state=IDLE, `lat_cnt=0`, `starve_cnt=0`, `rr_last=LS`, all `*_gnt`/`*_rvalid`/`mem_en`/`mem_we` = 0, and all data/address outputs = 0.
- Reset asserted mid-transaction aborts it: no `rvalid` is produced, and a store already strobed is not retracted.
- Grant is combinational in the request cycle, edge 0.
- Response arrives at edge MEM_LAT after the grant.
- Throughput:
  - MEM_LAT=1: one access per cycle, back-to-back.
  - MEM_LAT=N: one access per N cycles.
- Requesters must hold `req` and its operands stable until `gnt`. Dropping `req` before `gnt` is allowed and makes no access.
- Simultaneous requests are resolved by the policy; the loser sees `gnt=0` and stays pending.

## Configuration
- `MEM_ARB_RR_EN`:
  - Defined: round-robin policy. When both requesters are present, the one not equal to `rr_last` wins, and `rr_last` updates on every grant. `starve_cnt` is not implemented and `STARVE_MAX` is ignored.
  - Undefined: fixed LSU priority with the starvation guard described above.

## Structure
- Shared package `riscv_pkg`:
  - `owner_t` enum (OWN_IF, OWN_LS);
  - `arb_state_t` enum (ARB_IDLE, ARB_WAIT);
  - the opcode constants already used by the core.
- Sub-module `arb_pick`: combinational winner select. Inputs: `if_req`, `ls_req`, `starve_cnt`/`rr_last`. Output: one-hot grant. This keeps policy separate from sequencing.

## Test plan
- Reset release with `if_req=1`, `if_addr=0x8`: `if_gnt` in cycle 0 with `mem_addr=0x2`; at MEM_LAT=1, `if_rvalid=1` and `if_rdata=mem_rdata` in cycle 1.
- `ls_req` store `ls_addr=0x10`, `wdata=0xDEADBEEF`, `wstrb=0xF`: `mem_we=1`, `mem_addr=0x4`; the next cycle gives `ls_rvalid=1` with `ls_rdata=0`.
- Both requests held continuously, STARVE_MAX=4, default build: grants go LS,LS,LS,LS,IF, repeating. With `MEM_ARB_RR_EN` defined: grants alternate LS,IF,LS,IF.
- MEM_LAT=3 with back-to-back fetches: grants at cycles 0, 3, 6 and `if_rvalid` at cycles 3, 6, 9; no `mem_en` in cycles 1–2.
- `rst` driven low one cycle after an LS load grant: all outputs read 0 immediately, no `ls_rvalid` follows, and the next grant after release is normal.
- `if_req` dropped before grant (LS busy): no fetch access is issued and `starve_cnt` stops incrementing.
